hilo_div_unit: RTL and testbench

- Multi-cycle iterative divider in the EX stage, directly downstream of the main decoder.
- Started when the decoded aluop is DIV or DIVU and the instruction is not flushed.
- Stalls the pipeline while it computes, then hands the 64-bit {remainder, quotient} pair to the HILO write path.
- Radix-2 restoring algorithm, one quotient bit per cycle.

---
 rtl/hilo_div_unit.sv | 140 ++++++++++++++
 tb/tb_hilo_div_unit.sv | 218 +++++++++++++++++++++
 2 files changed

// File: rtl/hilo_div_unit.sv
// Radix-2 restoring divider for DIV/DIVU: one quotient bit per cycle and a {remainder, quotient} result.
// Optional macro DIV_ZERO_FAST_EN: a zero divisor takes a short IDLE->ZERO->DONE path and returns 0.
module hilo_div_unit #(
  parameter int WIDTH = 32
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start_i,
  input  logic               signed_div_i,
  input  logic [WIDTH-1:0]   opdata1_i,
  input  logic [WIDTH-1:0]   opdata2_i,
  input  logic               annul_i,
  output logic [2*WIDTH-1:0] result_o,
  output logic               ready_o,
  output logic               stall_o
);

  localparam int CNT_W = $clog2(WIDTH);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_CALC = 2'd1,
    S_DONE = 2'd2
`ifdef DIV_ZERO_FAST_EN
    , S_ZERO = 2'd3
`endif
  } state_t;

  state_t state, state_nx;

  logic [CNT_W-1:0] cnt_p0;
  logic [WIDTH-1:0] rem_p0;
  logic [WIDTH-1:0] dvd_p0;
  logic [WIDTH-1:0] dvs_p0;
  logic             neg_q_p0;
  logic             neg_r_p0;

  logic             sign1, sign2;
  logic [WIDTH:0]   rem_sh, trial;
  logic             q_bit, last_iter;
  logic [WIDTH-1:0] rem_nx, quot_nx;

  // Two's-complement negate when requested; the most negative value maps onto itself,
  // which is still the correct unsigned magnitude.
  function automatic logic [WIDTH-1:0] neg_if(input logic [WIDTH-1:0] v, input logic neg);
    logic signed [WIDTH-1:0] sv;
    sv = $signed(v);
    return neg ? $unsigned(-sv) : v;
  endfunction

  assign sign1 = signed_div_i & opdata1_i[WIDTH-1];
  assign sign2 = signed_div_i & opdata2_i[WIDTH-1];

  // Trial subtraction; bit WIDTH of the difference is the borrow (negative result).
  assign rem_sh    = {rem_p0, dvd_p0[WIDTH-1]};
  assign trial     = rem_sh - {1'b0, dvs_p0};
  assign q_bit     = ~trial[WIDTH];
  assign rem_nx    = q_bit ? trial[WIDTH-1:0] : rem_sh[WIDTH-1:0];
  assign quot_nx   = {dvd_p0[WIDTH-2:0], q_bit};
  assign last_iter = (cnt_p0 == CNT_W'(WIDTH - 1));

  always_ff @(posedge clk) begin
    if (rst) state <= S_IDLE;
    else     state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    if (annul_i) begin
      state_nx = S_IDLE;
    end else begin
      case (state)
        S_IDLE: begin
          if (start_i) begin
`ifdef DIV_ZERO_FAST_EN
            state_nx = (opdata2_i == '0) ? S_ZERO : S_CALC;
`else
            state_nx = S_CALC;
`endif
          end
        end
        S_CALC:  if (last_iter) state_nx = S_DONE;
        S_DONE:  state_nx = S_IDLE;
`ifdef DIV_ZERO_FAST_EN
        S_ZERO:  state_nx = S_DONE;
`endif
        default: state_nx = S_IDLE;
      endcase
    end
  end

  always_comb begin
    stall_o = 1'b0;
    ready_o = 1'b0;
    if (!annul_i) begin
      case (state)
        S_IDLE:  stall_o = start_i;
        S_CALC:  stall_o = 1'b1;
        S_DONE:  ready_o = 1'b1;
`ifdef DIV_ZERO_FAST_EN
        S_ZERO:  stall_o = 1'b1;
`endif
        default: stall_o = 1'b0;
      endcase
    end
  end

  // Operand latch (p0) and per-cycle iteration; result_o is only written on entry to DONE.
  always_ff @(posedge clk) begin
    if (rst) begin
      result_o <= '0;
      cnt_p0   <= '0;
    end else if (!annul_i) begin
      case (state)
        S_IDLE: begin
          if (start_i) begin
            dvd_p0   <= neg_if(opdata1_i, sign1);
            dvs_p0   <= neg_if(opdata2_i, sign2);
            neg_q_p0 <= sign1 ^ sign2;
            neg_r_p0 <= sign1;
            rem_p0   <= '0;
            cnt_p0   <= '0;
          end
        end
        S_CALC: begin
          rem_p0 <= rem_nx;
          dvd_p0 <= quot_nx;
          cnt_p0 <= cnt_p0 + 1'b1;
          if (last_iter)
            result_o <= {neg_if(rem_nx, neg_r_p0), neg_if(quot_nx, neg_q_p0)};
        end
`ifdef DIV_ZERO_FAST_EN
        S_ZERO: result_o <= '0;
`endif
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_hilo_div_unit.sv
// Scoreboard bench for hilo_div_unit: expected results are queued at issue and popped on ready_o.
module tb_hilo_div_unit;

  localparam int W = 32;

  logic           clk = 1'b0;
  logic           rst;
  logic           start_i;
  logic           signed_div_i;
  logic [W-1:0]   opdata1_i;
  logic [W-1:0]   opdata2_i;
  logic           annul_i;
  logic [2*W-1:0] result_o;
  logic           ready_o;
  logic           stall_o;

  int n_checks = 0;
  int n_fail   = 0;
  logic [63:0] exp_q[$];
  logic [63:0] last_result;

  hilo_div_unit #(.WIDTH(W)) dut (
    .clk          (clk),
    .rst          (rst),
    .start_i      (start_i),
    .signed_div_i (signed_div_i),
    .opdata1_i    (opdata1_i),
    .opdata2_i    (opdata2_i),
    .annul_i      (annul_i),
    .result_o     (result_o),
    .ready_o      (ready_o),
    .stall_o      (stall_o)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    n_checks++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s actual=%h required=%h", name, act, req);
    end
  endtask

  // Reference: plain integer division with truncation toward zero, remainder takes the dividend sign.
  function automatic logic [63:0] model(input bit sd, input logic [31:0] a, input logic [31:0] b);
    longint sa, sb, q, r;
    if (b == 32'd0) begin
`ifdef DIV_ZERO_FAST_EN
      return 64'd0;
`else
      return {a, (sd && a[31]) ? 32'd1 : 32'hFFFF_FFFF};
`endif
    end
    if (sd) begin
      sa = longint'($signed(a));
      sb = longint'($signed(b));
    end else begin
      sa = longint'({32'd0, a});
      sb = longint'({32'd0, b});
    end
    q = sa / sb;
    r = sa % sb;
    return {r[31:0], q[31:0]};
  endfunction

  function automatic int exp_lat(input logic [31:0] b);
`ifdef DIV_ZERO_FAST_EN
    if (b == 32'd0) return 2;
`endif
    return W + 1;
  endfunction

  // Monitor: every ready_o cycle must match the oldest outstanding expectation.
  initial begin
    logic [63:0] e;
    forever begin
      @(negedge clk);
      #1;
      if (ready_o === 1'b1) begin
        if (exp_q.size() == 0) begin
          check("unexpected_ready", {63'd0, ready_o}, 64'd0);
        end else begin
          e = exp_q.pop_front();
          check("result", result_o, e);
        end
      end
    end
  end

  task automatic drive(input bit sd, input logic [31:0] a, input logic [31:0] b, input bit push);
    signed_div_i = sd;
    opdata1_i    = a;
    opdata2_i    = b;
    start_i      = 1'b1;
    if (push) exp_q.push_back(model(sd, a, b));
  endtask

  // Counts cycles until ready_o (bounded) and the stall cycles seen on the way.
  task automatic wait_ready(output int n, output int st);
    n  = 0;
    st = 0;
    #1;
    if (stall_o) st++;
    do begin
      @(negedge clk);
      #1;
      n++;
      if (!ready_o && stall_o) st++;
    end while (!ready_o && n < 200);
    check("ready_stall_low", {63'd0, stall_o}, 64'd0);
  endtask

  task automatic run_op(input bit sd, input logic [31:0] a, input logic [31:0] b);
    int n, st;
    drive(sd, a, b, 1'b1);
    wait_ready(n, st);
    start_i = 1'b0;
    check("latency", 64'(n), 64'(exp_lat(b)));
    check("stall_cycles", 64'(st), 64'(exp_lat(b)));
    last_result = model(sd, a, b);
  endtask

  function automatic logic [31:0] rand_opnd();
    case ($urandom_range(0, 7))
      0:       return 32'd0;
      1:       return 32'h8000_0000;
      2:       return 32'hFFFF_FFFF;
      3:       return 32'($urandom_range(1, 20));
      default: return $urandom();
    endcase
  endfunction

  initial begin
    int n, st;
    rst = 1'b1; start_i = 1'b0; annul_i = 1'b0; signed_div_i = 1'b0;
    opdata1_i = '0; opdata2_i = '0;
    last_result = '0;
    repeat (3) @(negedge clk);
    #1;
    check("reset_ready", {63'd0, ready_o}, 64'd0);
    check("reset_stall", {63'd0, stall_o}, 64'd0);
    check("reset_result", result_o, 64'd0);
    rst = 1'b0;
    @(negedge clk); #1;

    run_op(1'b0, 32'd100, 32'd7);
    check("divu_100_7", result_o, {32'd2, 32'd14});
    @(negedge clk); #1;
    run_op(1'b1, 32'hFFFF_FFF9, 32'd2);
    check("div_m7_2", result_o, {32'hFFFF_FFFF, 32'hFFFF_FFFD});
    @(negedge clk); #1;
    run_op(1'b1, 32'h8000_0000, 32'hFFFF_FFFF);
    check("div_overflow", result_o, {32'h0, 32'h8000_0000});
    @(negedge clk); #1;
    run_op(1'b0, 32'd7, 32'd0);
`ifdef DIV_ZERO_FAST_EN
    check("divu_7_0", result_o, 64'd0);
`else
    check("divu_7_0", result_o, {32'd7, 32'hFFFF_FFFF});
`endif
    @(negedge clk); #1;

    // Back-to-back: start stays high through DONE, second operand set in the ready cycle.
    drive(1'b0, 32'd9, 32'd3, 1'b1);
    wait_ready(n, st);
    check("b2b_first", result_o, {32'd0, 32'd3});
    drive(1'b0, 32'd10, 32'd4, 1'b1);
    wait_ready(n, st);
    start_i = 1'b0;
    check("b2b_gap", 64'(n), 64'(W + 2));
    check("b2b_second", result_o, {32'd2, 32'd2});
    last_result = {32'd2, 32'd2};
    @(negedge clk); #1;

    // Annul during CALC: no result, no pulse.
    drive(1'b1, 32'd12345, 32'd17, 1'b0);
    repeat (6) @(negedge clk);
    #1;
    annul_i = 1'b1; start_i = 1'b0;
    #1;
    check("annul_stall", {63'd0, stall_o}, 64'd0);
    check("annul_ready", {63'd0, ready_o}, 64'd0);
    @(negedge clk); #1;
    annul_i = 1'b0;
    #1;
    check("post_annul_stall", {63'd0, stall_o}, 64'd0);
    check("post_annul_result", result_o, last_result);
    repeat (40) @(negedge clk);
    #1;
    check("annul_result_held", result_o, last_result);

    // Reset during CALC.
    drive(1'b0, 32'hDEAD_BEEF, 32'd3, 1'b0);
    repeat (11) @(negedge clk);
    #1;
    rst = 1'b1; start_i = 1'b0;
    @(negedge clk); #1;
    check("midrst_stall", {63'd0, stall_o}, 64'd0);
    check("midrst_ready", {63'd0, ready_o}, 64'd0);
    check("midrst_result", result_o, 64'd0);
    rst = 1'b0;
    repeat (40) @(negedge clk);
    #1;

    for (int i = 0; i < 25; i++) begin
      run_op(1'($urandom_range(0, 1)), rand_opnd(), rand_opnd());
      repeat ($urandom_range(1, 3)) @(negedge clk);
      #1;
    end

    repeat (3) @(negedge clk);
    check("queue_empty", 64'(exp_q.size()), 64'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
